// File: rtl/imm_gen_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe_if
// Purpose : bundles the two valid/ready handshakes of imm_gen_pipe.
//   Upstream side  : in_valid, in_ready, in_instr, in_tag
//   Downstream side: out_valid, out_ready, out_imm, out_fmt, out_illegal,
//                    out_tag
// Modports:
//   master - the environment: drives instructions and consumer ready.
//   slave  - imm_gen_pipe itself.
// Parameters:
//   XLEN  - width of the decoded immediate (32 or 64).
//   TAG_W - width of the sideband tag.
// ----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Purpose : registered RV32I/RV64I immediate generator. Decodes the I, S, B,
//           U and J immediate formats, flags unknown opcodes, and buffers the
//           result in a two-entry (main + skid) output stage so the block
//           sustains one instruction per cycle under backpressure.
// Ports:
//   clk         - rising-edge clock.
//   reset       - synchronous, active-high reset.
//   flush       - synchronous; empties both buffer entries, drops any input.
//   bus         - imm_gen_pipe_if.slave (input and output handshakes).
//   illegal_cnt - saturating count of accepted illegal instructions.
// Parameters:
//   XLEN  - immediate width, 32 or 64.
//   TAG_W - sideband tag width.
//   CNT_W - illegal-opcode counter width.
// Build option:
//   IMM_GEN_ZICSR_EN - when defined, SYSTEM opcodes decode (CSR immediate
//   forms as fmt 6 with zero-extended zimm, others as I-type). When
//   undefined, every SYSTEM opcode is illegal.
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ZIMM    = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]      instr;
    logic [31:0]      raw_imm;
    fmt_e             dec_fmt;
    logic             dec_illegal;
    entry_t           new_entry;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             handoff;

    assign instr = bus.in_instr;

    // Combinational decode. Every format first builds a 32-bit immediate
    // whose bit 31 is the sign; one signed cast then widens it to XLEN, so
    // U-type upper bits are sign-filled on RV64. Illegal and R-type leave
    // the immediate at zero so no unused instruction bits leak through.
    always_comb begin
        raw_imm     = '0;
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                raw_imm = {{20{instr[31]}}, instr[31:20]};
                dec_fmt = FMT_I;
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    raw_imm = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt = FMT_I;
                end else begin
                    dec_fmt     = FMT_ILLEGAL;
                    dec_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                raw_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt = FMT_S;
            end
            OP_BRANCH: begin
                raw_imm = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                raw_imm = {instr[31:12], 12'b0};
                dec_fmt = FMT_U;
            end
            OP_JAL: begin
                raw_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            OP_REG: begin
                dec_fmt = FMT_R;
            end
            OP_REG_32: begin
                if (XLEN != 64) begin
                    dec_fmt     = FMT_ILLEGAL;
                    dec_illegal = 1'b1;
                end
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                // funct3 values 101/110/111 are the CSR*I forms whose
                // rs1 field carries a 5-bit unsigned immediate.
                if (instr[14:12] == 3'b101 || instr[14:12] == 3'b110 ||
                    instr[14:12] == 3'b111) begin
                    raw_imm = {27'b0, instr[19:15]};
                    dec_fmt = FMT_ZIMM;
                end else begin
                    raw_imm = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt = FMT_I;
                end
`else
                dec_fmt     = FMT_ILLEGAL;
                dec_illegal = 1'b1;
`endif
            end
            default: begin
                dec_fmt     = FMT_ILLEGAL;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Pack the decoded result with its tag into a buffer entry.
    always_comb begin
        new_entry.imm     = XLEN'($signed(raw_imm));
        new_entry.fmt     = dec_fmt;
        new_entry.illegal = dec_illegal;
        new_entry.tag     = bus.in_tag;
    end

    // in_ready is just "skid empty", taken straight from a flop, so the
    // consumer's out_ready never reaches in_ready combinationally.
    assign accept  = bus.in_valid && !skid_valid_q && !flush;
    assign handoff = main_valid_q && bus.out_ready;

    // Buffer next-state. The main entry drives the outputs; the skid entry
    // only fills when main is occupied, not leaving, and a new instruction
    // arrives. Because in_ready is low whenever skid is full, skid refill
    // and accept never collide. Flush empties both entries and suppresses
    // the accept (and its counter increment).
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    main_d = new_entry;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (!main_valid_q) begin
                if (accept) begin
                    main_d       = new_entry;
                    main_valid_d = 1'b1;
                end
            end else if (accept) begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end

            if (accept && dec_illegal && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset; reset overrides flush and
    // both handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_tag     = main_q.tag;
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives one stimulus stream into two imm_gen_pipe instances in lockstep:
// an RV32 build with an 8-bit counter and an RV64 build with a 2-bit
// counter. Expected entries are pushed to a per-instance queue when an
// instruction is accepted and popped when the DUT hands one off.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        out_ready;
    logic [7:0]  cnt32;
    logic [1:0]  cnt64;

    int   checks;
    int   failures;
    bit   random_mode;
    exp_t q32[$];
    exp_t q64[$];
    int   mcnt32;
    int   mcnt64;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) u_dut32 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus32.slave),
        .illegal_cnt (cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) u_dut64 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus64.slave),
        .illegal_cnt (cnt64)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference decode written directly from the instruction formats.
    function automatic void modelDecode(input logic [31:0] i, input bit x64,
                                        output logic [63:0] imm,
                                        output logic [2:0] fmt,
                                        output logic ill);
        logic [31:0] v;
        logic [31:0] i_type;
        v      = 32'h0;
        fmt    = 3'd0;
        ill    = 1'b0;
        i_type = {{20{i[31]}}, i[31:20]};
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin v = i_type; fmt = 3'd1; end
            7'b0011011: begin
                if (x64) begin v = i_type; fmt = 3'd1; end
                else ill = 1'b1;
            end
            7'b0100011: begin v = {{20{i[31]}}, i[31:25], i[11:7]}; fmt = 3'd2; end
            7'b1100011: begin
                v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                fmt = 3'd3;
            end
            7'b0110111, 7'b0010111: begin v = {i[31:12], 12'h000}; fmt = 3'd4; end
            7'b1101111: begin
                v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                fmt = 3'd5;
            end
            7'b0110011: fmt = 3'd0;
            7'b0111011: if (!x64) ill = 1'b1;
            7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
                if (i[14] && (i[13] || i[12])) begin
                    v = {27'h0, i[19:15]};
                    fmt = 3'd6;
                end else begin
                    v = i_type;
                    fmt = 3'd1;
                end
`else
                ill = 1'b1;
`endif
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            v   = 32'h0;
            fmt = 3'd7;
        end
        imm = x64 ? {{32{v[31]}}, v} : {32'h0, v};
    endfunction

    // Scoreboard monitor, sampled on the falling edge while inputs are
    // stable: first checks any handoff about to happen against the queue
    // head, then records any accept about to happen. Flush and reset
    // empty the queues; reset also clears the counter models.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q32.delete();
            q64.delete();
            mcnt32 = 0;
            mcnt64 = 0;
        end else begin
            if (bus32.out_valid && bus32.out_ready) begin
                checkOutput("sb32_nonempty", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    checkOutput("sb32_imm", {32'h0, bus32.out_imm}, e.imm);
                    checkOutput("sb32_fmt", 64'(bus32.out_fmt), 64'(e.fmt));
                    checkOutput("sb32_ill", 64'(bus32.out_illegal), 64'(e.ill));
                    checkOutput("sb32_tag", 64'(bus32.out_tag), 64'(e.tag));
                end
            end
            if (bus64.out_valid && bus64.out_ready) begin
                checkOutput("sb64_nonempty", 64'(q64.size() != 0), 64'd1);
                if (q64.size() != 0) begin
                    e = q64.pop_front();
                    checkOutput("sb64_imm", bus64.out_imm, e.imm);
                    checkOutput("sb64_fmt", 64'(bus64.out_fmt), 64'(e.fmt));
                    checkOutput("sb64_ill", 64'(bus64.out_illegal), 64'(e.ill));
                    checkOutput("sb64_tag", 64'(bus64.out_tag), 64'(e.tag));
                end
            end
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (in_valid && bus32.in_ready) begin
                    modelDecode(in_instr, 1'b0, e.imm, e.fmt, e.ill);
                    e.tag = in_tag;
                    q32.push_back(e);
                    if (e.ill && mcnt32 < 255) mcnt32++;
                end
                if (in_valid && bus64.in_ready) begin
                    modelDecode(in_instr, 1'b1, e.imm, e.fmt, e.ill);
                    e.tag = in_tag;
                    q64.push_back(e);
                    if (e.ill && mcnt64 < 3) mcnt64++;
                end
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded wait).
    // Returns one tick after the accepting edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [4:0] tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        @(negedge clk);
        while (!bus32.in_ready && n < 64) begin
            @(posedge clk);
            #1;
            if (random_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        checkOutput("accept_wait", 64'(n < 64), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (random_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid32"}, 64'(bus32.out_valid), 64'd0);
        checkOutput({tag, "_ready32"}, 64'(bus32.in_ready), 64'd1);
        checkOutput({tag, "_valid64"}, 64'(bus64.out_valid), 64'd0);
        checkOutput({tag, "_ready64"}, 64'(bus64.in_ready), 64'd1);
    endtask

    logic [6:0] ops [12];

    initial begin
        logic [31:0] r;
        checks      = 0;
        failures    = 0;
        random_mode = 1'b0;
        reset       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'h0;
        in_tag      = 5'd0;
        out_ready   = 1'b0;
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b1101111, 7'b0110011, 7'b0111011,
                7'b1110011, 7'b1111111};
        #1;
        doReset();

        // Reset state.
        checkIdle("rst");
        checkOutput("rst_imm", {32'h0, bus32.out_imm}, 64'h0);
        checkOutput("rst_fmt", 64'(bus32.out_fmt), 64'd0);
        checkOutput("rst_ill", 64'(bus32.out_illegal), 64'd0);
        checkOutput("rst_tag", 64'(bus32.out_tag), 64'd0);
        checkOutput("rst_cnt", 64'(cnt32), 64'd0);

        // addi x1,x2,-4: visible one edge after accept.
        out_ready = 1'b1;
        applyStimulus(32'hFFC10093, 5'd1);
        checkOutput("addi_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("addi_imm", {32'h0, bus32.out_imm}, 64'hFFFF_FFFC);
        checkOutput("addi_fmt", 64'(bus32.out_fmt), 64'd1);

        // beq -4 then jal +8 back to back, one per cycle.
        applyStimulus(32'hFE000EE3, 5'd2);
        checkOutput("beq_imm", {32'h0, bus32.out_imm}, 64'hFFFF_FFFC);
        checkOutput("beq_fmt", 64'(bus32.out_fmt), 64'd3);
        applyStimulus(32'h0080006F, 5'd3);
        checkOutput("jal_imm", {32'h0, bus32.out_imm}, 64'h0000_0008);
        checkOutput("jal_fmt", 64'(bus32.out_fmt), 64'd5);

        // lui with bit 31 set: sign-filled on RV64.
        applyStimulus(32'h800000B7, 5'd4);
        checkOutput("lui64_imm", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
        checkOutput("lui64_fmt", 64'(bus64.out_fmt), 64'd4);
        checkOutput("lui32_imm", {32'h0, bus32.out_imm}, 64'h8000_0000);
        tick(2);

        // Backpressure: tags 1,2 fill main+skid, tag 3 stalls.
        out_ready = 1'b0;
        applyStimulus(32'h00500093, 5'd1);
        applyStimulus(32'h00600093, 5'd2);
        in_valid = 1'b1;
        in_instr = 32'h00700093;
        in_tag   = 5'd3;
        tick(3);
        checkOutput("stall_ready", 64'(bus32.in_ready), 64'd0);
        checkOutput("stall_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("stall_tag", 64'(bus32.out_tag), 64'd1);
        out_ready = 1'b1;
        applyStimulus(32'h00700093, 5'd3);
        tick(4);
        checkOutput("drain_q32", 64'(q32.size()), 64'd0);
        checkOutput("drain_q64", 64'(q64.size()), 64'd0);

        // Illegal opcodes: 2-bit counter saturates at 3, flush keeps it.
        for (int k = 0; k < 5; k++) applyStimulus(32'h0000007F, 5'(k + 8));
        tick(2);
        checkOutput("ill_cnt64", 64'(cnt64), 64'd3);
        checkOutput("ill_cnt32", 64'(cnt32), 64'(mcnt32));
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        checkOutput("flush_cnt64", 64'(cnt64), 64'd3);

        // Skid full, flush together with in_valid: nothing survives.
        out_ready = 1'b0;
        applyStimulus(32'h00100013, 5'd11);
        applyStimulus(32'h00200013, 5'd12);
        in_valid = 1'b1;
        in_instr = 32'h00300013;
        in_tag   = 5'd13;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkIdle("flush_full");
        out_ready = 1'b1;
        tick(3);

        // Flush wins over an accept; the dropped illegal is not counted.
        out_ready = 1'b0;
        applyStimulus(32'h00100013, 5'd14);
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        in_tag   = 5'd15;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkIdle("flush_acc");
        checkOutput("flush_acc_cnt32", 64'(cnt32), 64'(mcnt32));
        out_ready = 1'b1;
        tick(3);

        // Mixed random traffic with random backpressure.
        random_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
            applyStimulus(r, 5'(k));
        end
        random_mode = 1'b0;
        out_ready   = 1'b1;
        tick(5);
        checkOutput("rand_q32", 64'(q32.size()), 64'd0);
        checkOutput("rand_q64", 64'(q64.size()), 64'd0);
        checkOutput("rand_cnt32", 64'(cnt32), 64'(mcnt32));
        checkOutput("rand_cnt64", 64'(cnt64), 64'(mcnt64));

        // Reset in the middle of buffered traffic.
        out_ready = 1'b0;
        applyStimulus(32'h0000007F, 5'd20);
        applyStimulus(32'h00000013, 5'd21);
        doReset();
        checkIdle("midrst");
        checkOutput("midrst_cnt32", 64'(cnt32), 64'd0);
        checkOutput("midrst_cnt64", 64'(cnt64), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised successor to the single-cycle immediate generator.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J) and flags unsupported opcodes.
- Sits between fetch/decode and execute in the pipelined core; valid/ready handshakes on both sides.
- Two-entry output buffer (main + skid) gives full throughput under backpressure; saturating illegal-opcode counter for debug.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64; sign extension fills to XLEN.
- TAG_W, 5, width of sideband tag (e.g. rd index or ROB id) carried alongside the instruction.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  instruction presented.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  raw instruction word; opcode is in_instr[6:0].
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  consumer accepts this cycle.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR-zimm, 7=illegal.
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the entry on out_*.
- illegal_cnt  output  CNT_W  count of accepted illegal instructions; saturates.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0.
  - Both buffer entries empty; in_ready=1 in the cycle after reset.
- Accept and handoff:
  - Accept when in_valid && in_ready. Handoff when out_valid && out_ready.
  - in_ready = skid entry empty. It is registered, so there is no combinational path from out_ready.
- Latency and ordering:
  - 1 cycle: an entry accepted at edge N appears on out_* after edge N.
  - Throughput is 1 per cycle while out_ready=1.
  - Strict FIFO order; no entry is dropped or duplicated.
- Backpressure:
  - If main is full and not handed off when a new entry is accepted, the new entry goes to skid, and in_ready falls.
  - When main hands off, skid moves to main and in_ready rises.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Decode (i = in_instr; sext = sign extend from the MSB shown to XLEN):
  - I: opcodes 0000011, 0010011, 1100111, plus 0011011 when XLEN=64. imm = sext(i[31:20]).
  - S: 0100011. imm = sext({i[31:25], i[11:7]}).
  - B: 1100011. imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: 0110111, 0010111. imm = sext({i[31:12], 12'b0}); upper bits are sign-filled when XLEN=64.
  - J: 1101111. imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - R: 0110011, plus 0111011 when XLEN=64. imm=0, fmt=0.
  - Any other opcode: imm=0, fmt=7, out_illegal=1.
  - Decode is combinational on in_instr and captured at accept. Unused bits never leak into the result.
- illegal_cnt:
  - +1 on each accepted illegal instruction.
  - Holds at 2^CNT_W-1 once reached.
  - Unaffected by flush; cleared only by reset.
- flush:
  - Next cycle: out_valid=0, both entries empty, in_ready=1.
  - Flush and accept in the same cycle: flush wins. The input is dropped and not counted.
- Reset mid-operation overrides flush and all handshakes.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3 (i[14:12]) in {101, 110, 111} decodes as fmt=6, imm = zero-extend(i[19:15]). Other 1110011 encodings decode as I-type (sext(i[31:20]), the CSR address).
- Undefined: every 1110011 encoding is illegal (fmt=7) and increments illegal_cnt.

Test Plan:
- Reset, then in_instr=0xFFC10093 (addi x1,x2,-4), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFC, fmt=1.
- B-type 0xFE000EE3 (beq offset -4), then J-type 0x0080006F (jal +8), back-to-back -> imm 0xFFFFFFFC fmt=3, then 0x00000008 fmt=5, one per cycle.
- XLEN=64, lui 0x800000B7 -> out_imm=0xFFFFFFFF80000000, fmt=4.
- out_ready=0, push 3 instrs with tags 1,2,3 -> third stalls with in_ready=0; raise out_ready -> tags 1,2,3 emerge in order, none lost.
- CNT_W=2, accept 5 instrs with opcode 0x7F -> fmt=7, illegal=1 on each; illegal_cnt ends at 3; flush keeps it at 3.
- Skid full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, dropped entry never appears.
